// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues req/ack reads to instruction
// memory, and loads the IF/ID instruction register. A one-entry skid buffer
// catches a return that lands while decode is stalled. Redirects that arrive
// with a request still in flight park in DISCARD until the stale word is
// returned and dropped.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        reloj,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        if_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic [4:0]  dir_a,
  output logic [4:0]  dir_b,
  output logic [4:0]  dir_wra,
  output logic [15:0] imd,
  output logic [25:0] address,
  output logic [3:0]  pc_4
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_FULL    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  localparam logic [31:0] STEP = 32'(PC_STEP);

  logic [1:0]  state_q,      state_d;
  logic [31:0] pc_q,         pc_d;          // address of the next/outstanding fetch
  logic [31:0] redir_pc_q,   redir_pc_d;    // target parked while in DISCARD
  logic [31:0] ir_q,         ir_d;
  logic [31:0] ir_pc4_q,     ir_pc4_d;
  logic        ir_valid_q,   ir_valid_d;
  logic [31:0] skid_q,       skid_d;
  logic [31:0] skid_pc4_q,   skid_pc4_d;
  logic        skid_valid_q, skid_valid_d;

  logic [31:0] target;
  logic [31:0] pc_next;
  logic        consume;

  assign target  = redirect_pc & 32'hFFFF_FFFC;   // low address bits are ignored
  assign pc_next = pc_q + STEP;                   // wraps modulo 2^32
  assign consume = ir_valid_q && !stall;

  // Next-state logic for the FSM, PC, instruction register and skid buffer.
  always_comb begin
    // NOTE: every _d is defaulted to its _q first so no path through the
    // branches below can leave a signal unassigned and infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    redir_pc_d   = redir_pc_q;
    ir_d         = ir_q;
    ir_pc4_d     = ir_pc4_q;
    ir_valid_d   = ir_valid_q;
    skid_d       = skid_q;
    skid_pc4_d   = skid_pc4_q;
    skid_valid_d = skid_valid_q;

    if (redirect) begin
      // Redirect overrides stall: the IR and skid are flushed unconditionally.
      ir_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
      if ((state_q == S_REQ || state_q == S_DISCARD) && !imem_ack) begin
        // A read is still in flight: keep its address until the ack, then drop it.
        state_d    = S_DISCARD;
        redir_pc_d = target;
      end else begin
        // Nothing outstanding (or it returns now and is dropped): fetch the target.
        state_d = S_REQ;
        pc_d    = target;
      end
    end else begin
      // Decode takes the IR; the skid refills it ahead of any memory return.
      if (consume) begin
        if (skid_valid_q) begin
          ir_d         = skid_q;
          ir_pc4_d     = skid_pc4_q;
          skid_valid_d = 1'b0;
        end else begin
          ir_valid_d = 1'b0;
        end
      end

      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (imem_ack) begin
            pc_d = pc_next;
            if (!ir_valid_d) begin
              ir_d       = imem_data;
              ir_pc4_d   = pc_next;
              ir_valid_d = 1'b1;
              state_d    = S_REQ;
            end else begin
              skid_d       = imem_data;
              skid_pc4_d   = pc_next;
              skid_valid_d = 1'b1;
              state_d      = S_FULL;
            end
          end
        end
        S_FULL: begin
          if (!stall) state_d = S_REQ;
        end
        S_DISCARD: begin
          if (imem_ack) begin
            state_d = S_REQ;
            pc_d    = redir_pc_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      redir_pc_q   <= RESET_PC;
      ir_q         <= 32'h0;
      ir_pc4_q     <= 32'h0;
      ir_valid_q   <= 1'b0;
      skid_q       <= 32'h0;
      skid_pc4_q   <= 32'h0;
      skid_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed for this edge, independent of statement order.
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_pc_q   <= redir_pc_d;
      ir_q         <= ir_d;
      ir_pc4_q     <= ir_pc4_d;
      ir_valid_q   <= ir_valid_d;
      skid_q       <= skid_d;
      skid_pc4_q   <= skid_pc4_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Memory request: held with the outstanding address in REQ and DISCARD.
  assign imem_req  = (state_q == S_REQ) || (state_q == S_DISCARD);
  assign imem_addr = pc_q;

  // Decode-facing outputs are plain slices of the IF/ID register.
  assign if_valid = ir_valid_q;
  assign instr    = ir_q;
  assign pc_plus4 = ir_pc4_q;
  assign dir_a    = ir_q[25:21];
  assign dir_b    = ir_q[20:16];
  assign dir_wra  = ir_q[15:11];
  assign imd      = ir_q[15:0];
  assign address  = ir_q[25:0];
  assign pc_4     = ir_pc4_q[31:28];

endmodule
